// File: rtl/instr_fetch.sv
// instr_fetch: PC owner, single-outstanding imem requester and QDEPTH-entry instruction queue.
// Optional INSTR_FETCH_PERF_EN adds fetch_cnt/flush_cnt performance counters.
module instr_fetch #(
    parameter int              PC_W     = 64,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic [5:0]         opcode,
    output logic [5:0]         funct
`ifdef INSTR_FETCH_PERF_EN
    ,
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        flush_cnt
`endif
);
    localparam int AW = $clog2(QDEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(QDEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t             state, state_n;
    logic [PC_W-1:0]    fetch_pc, fetch_pc_n, addr_q, addr_n, redir_pc;
    logic [PC_W-1:0]    pc_q [QDEPTH];
    logic [INSTR_W-1:0] ins_q [QDEPTH];
    logic [AW-1:0]      rd_ptr, wr_ptr;
    logic [AW:0]        count;
    logic               push, pop;

    assign imem_req    = state != IDLE;
    assign imem_addr   = addr_q;
    assign instr_valid = count != '0;
    assign instr       = ins_q[rd_ptr];
    assign instr_pc    = pc_q[rd_ptr];
    assign opcode      = instr[31:26];
    assign funct       = instr[5:0];

    always_comb begin
        redir_pc   = redirect_pc & ~PC_W'(3);
        push       = state == WAIT && imem_ack && !redirect_valid;
        pop        = instr_valid && instr_ready;
        state_n    = state;
        fetch_pc_n = fetch_pc;
        addr_n     = addr_q;
        if (redirect_valid) begin
            fetch_pc_n = redir_pc;
            // an unacked request must still complete at its old address, so park in DROP
            if (state != IDLE && !imem_ack) begin
                state_n = DROP;
            end else begin
                state_n = WAIT;
                addr_n  = redir_pc;
            end
        end else begin
            case (state)
                IDLE: if (count != FULL) begin
                    state_n = WAIT;
                    addr_n  = fetch_pc;
                end
                WAIT: if (imem_ack) begin
                    state_n    = IDLE;
                    fetch_pc_n = fetch_pc + PC_W'(4);
                end
                default: state_n = imem_ack ? IDLE : DROP;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            addr_q   <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                pc_q[i]  <= '0;
                ins_q[i] <= '0;
            end
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            addr_q   <= addr_n;
            if (redirect_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    pc_q[wr_ptr]  <= fetch_pc;
                    ins_q[wr_ptr] <= imem_rdata;
                    wr_ptr        <= wr_ptr + 1'b1;
                end
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= count + (AW+1)'(push) - (AW+1)'(pop);
            end
        end
    end

`ifdef INSTR_FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (push)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (redirect_valid)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized bench for instr_fetch against a queue-based transaction model.
module tb_instr_fetch;
    localparam logic [63:0] RPC = 64'h100;
    localparam int          QD  = 2;

    logic        clk = 0, rst = 0;
    logic        imem_req, imem_ack = 0, redirect_valid = 0, instr_valid, instr_ready = 0;
    logic [63:0] imem_addr, redirect_pc = '0, instr_pc;
    logic [31:0] imem_rdata = '0, instr;
    logic [5:0]  opcode, funct;
`ifdef INSTR_FETCH_PERF_EN
    logic [31:0] fetch_cnt, flush_cnt;
`endif

    instr_fetch #(.PC_W(64), .INSTR_W(32), .RESET_PC(RPC), .QDEPTH(QD)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .opcode(opcode), .funct(funct)
`ifdef INSTR_FETCH_PERF_EN
        , .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [63:0] mq_pc [$];
    logic [31:0] mq_ins [$];
    logic [63:0] exp_fetch, next_addr;
    logic        next_req, stale;
    int unsigned m_fetch, m_flush;
    int          n_tests = 0, n_fail = 0;

    function automatic logic [31:0] mem_fn(input logic [63:0] a);
        return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A0F0F;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_perf();
`ifdef INSTR_FETCH_PERF_EN
        check("fetch_cnt", 64'(fetch_cnt), 64'(m_fetch));
        check("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`endif
    endtask

    task automatic model_reset();
        mq_pc.delete();
        mq_ins.delete();
        exp_fetch = RPC;
        next_addr = RPC;
        next_req  = 0;
        stale     = 0;
        m_fetch   = 0;
        m_flush   = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        imem_ack = 0;
        redirect_valid = 0;
        instr_ready = 0;
        @(negedge clk);
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_addr", imem_addr, RPC);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_pc", instr_pc, 64'd0);
        check("rst_opcode", 64'(opcode), 64'd0);
        check("rst_funct", 64'(funct), 64'd0);
        model_reset();
        check_perf();
        @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic check_outputs();
        logic [31:0] e;
        check("req", 64'(imem_req), 64'(next_req));
        if (next_req)
            check("addr", imem_addr, next_addr);
        check("valid", 64'(instr_valid), 64'(mq_pc.size() != 0));
        if (mq_pc.size() != 0) begin
            e = mq_ins[0];
            check("head_pc", instr_pc, mq_pc[0]);
            check("head_instr", 64'(instr), 64'(e));
            check("opcode", 64'(opcode), 64'(e[31:26]));
            check("funct", 64'(funct), 64'(e[5:0]));
        end
        check_perf();
    endtask

    // Transaction-level effect of the coming clock edge, from the visible handshakes.
    task automatic model_step();
        int          sz;
        logic [63:0] tgt;
        sz  = mq_pc.size();
        tgt = redirect_pc & ~64'h3;
        if (redirect_valid) begin
            m_flush++;
            mq_pc.delete();
            mq_ins.delete();
            exp_fetch = tgt;
            next_req  = 1;
            if (imem_req && !imem_ack) begin
                stale     = 1;
                next_addr = imem_addr;
            end else begin
                stale     = 0;
                next_addr = tgt;
            end
        end else begin
            if (sz != 0 && instr_ready) begin
                void'(mq_pc.pop_front());
                void'(mq_ins.pop_front());
            end
            if (imem_req && imem_ack) begin
                if (!stale) begin
                    mq_pc.push_back(exp_fetch);
                    mq_ins.push_back(imem_rdata);
                    m_fetch++;
                    exp_fetch = exp_fetch + 64'd4;
                end
                stale    = 0;
                next_req = 0;
            end else if (imem_req) begin
                next_req  = 1;
                next_addr = imem_addr;
            end else begin
                next_req  = sz < QD;
                next_addr = exp_fetch;
            end
        end
    endtask

    function automatic logic [63:0] pick_target();
        case ($urandom_range(3))
            0: return 64'h2003;
            1: return 64'hFFFF_FFFF_FFFF_FFFD;
            2: return 64'hFFFF_FFFF_FFFF_FFF8;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic run(input int n, input int ack_pct, input int rdy_pct, input int red_pct);
        for (int i = 0; i < n; i++) begin
            imem_ack       = imem_req && ($urandom_range(99) < ack_pct);
            imem_rdata     = mem_fn(imem_addr);
            instr_ready    = $urandom_range(99) < rdy_pct;
            redirect_valid = $urandom_range(99) < red_pct;
            redirect_pc    = pick_target();
            @(negedge clk);
            check_outputs();
            model_step();
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        do_reset();
        run(40, 100, 100, 0);
        run(20, 100, 0, 0);
        check("stall_req", 64'(imem_req), 64'd0);
        run(30, 100, 100, 0);
        run(400, 50, 70, 5);
        run(300, 30, 40, 10);
        run(7, 60, 60, 10);
        do_reset();
        run(400, 60, 80, 3);
        run(200, 100, 100, 20);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
